// File: rtl/result_skid_16_if.sv
// result_skid_16_if: upstream/downstream handshake bundle for the 16-bit result skid buffer
interface result_skid_16_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        zero_flag;
  logic        neg_flag;
  logic [7:0]  xfer_count;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, zero_flag, neg_flag, xfer_count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, zero_flag, neg_flag, xfer_count
  );
endinterface

// File: rtl/result_skid_16.sv
// result_skid_16: 2-entry skid buffer for inverter results; RESULT_SKID_FLAGS_EN enables zero/neg flags
module result_skid_16 (
  input logic             clk,
  input logic             rst_n,
  result_skid_16_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t      state, state_nx;
  logic [15:0] head, tail, head_nx, tail_nx;
  logic [7:0]  cnt;
  logic        in_xfer, out_xfer;
  // handshake outputs decode the state register only, so ready never follows out_ready
  assign bus.in_ready   = state != TWO;
  assign bus.out_valid  = state != EMPTY;
  assign bus.out_data   = bus.out_valid ? head : 16'h0000;
  assign bus.xfer_count = cnt;
  assign in_xfer        = bus.in_valid && bus.in_ready;
  assign out_xfer       = bus.out_valid && bus.out_ready;
`ifdef RESULT_SKID_FLAGS_EN
  assign bus.zero_flag = bus.out_valid && head == 16'h0000;
  assign bus.neg_flag  = bus.out_valid && head[15];
`else
  assign bus.zero_flag = 1'b0;
  assign bus.neg_flag  = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    head_nx  = head;
    tail_nx  = tail;
    case (state)
      EMPTY: begin
        state_nx = in_xfer ? ONE : EMPTY;
        head_nx  = in_xfer ? bus.in_data : head;
      end
      ONE: begin
        state_nx = in_xfer == out_xfer ? ONE : in_xfer ? TWO : EMPTY;
        head_nx  = in_xfer && out_xfer ? bus.in_data : head;
        tail_nx  = in_xfer ? bus.in_data : tail;
      end
      TWO: begin
        state_nx = out_xfer ? ONE : TWO;
        head_nx  = out_xfer ? tail : head;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= 16'h0000;
      tail  <= 16'h0000;
      cnt   <= 8'h00;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      tail  <= tail_nx;
      if (out_xfer) cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_result_skid_16.sv
// tb_result_skid_16: directed and scoreboarded checks of the result skid buffer
module tb_result_skid_16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
`ifdef RESULT_SKID_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  result_skid_16_if bus ();
  result_skid_16 dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 16'hDEAD, 1'b1);
    tick();
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
        bus.zero_flag !== 1'b0 || bus.neg_flag !== 1'b0 || bus.xfer_count !== 8'h00) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b data=%h z=%b n=%b cnt=%h want 1 0 0000 0 0 00",
               bus.in_ready, bus.out_valid, bus.out_data, bus.zero_flag, bus.neg_flag, bus.xfer_count);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    drive(1'b1, 16'h00FF, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00FF || bus.zero_flag !== 1'b0 ||
        bus.neg_flag !== 1'b0 || bus.xfer_count !== 8'h00) begin
      fails++;
      $display("FAIL single_out: vld=%b data=%h z=%b n=%b cnt=%h want 1 00ff 0 0 00",
               bus.out_valid, bus.out_data, bus.zero_flag, bus.neg_flag, bus.xfer_count);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.xfer_count !== 8'h01) begin
      fails++;
      $display("FAIL single_drain: vld=%b cnt=%h want 0 01", bus.out_valid, bus.xfer_count);
    end
  endtask
  task automatic test_fill();
    drive(1'b1, 16'h8000, 1'b0);
    tick();
    drive(1'b1, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 16'h1234, 1'b0);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000 ||
        bus.neg_flag !== FL || bus.zero_flag !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: rdy=%b vld=%b data=%h n=%b z=%b want 0 1 8000 %b 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.neg_flag, bus.zero_flag, FL);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b1);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 16'h8000 || bus.neg_flag !== FL) begin
      fails++;
      $display("FAIL fill_hold: rdy=%b data=%h n=%b want 0 8000 %b",
               bus.in_ready, bus.out_data, bus.neg_flag, FL);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000 || bus.zero_flag !== FL ||
        bus.neg_flag !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_second: vld=%b data=%h z=%b n=%b rdy=%b want 1 0000 %b 0 1",
               bus.out_valid, bus.out_data, bus.zero_flag, bus.neg_flag, bus.in_ready, FL);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.xfer_count !== 8'h03) begin
      fails++;
      $display("FAIL fill_empty: vld=%b data=%h cnt=%h want 0 0000 03",
               bus.out_valid, bus.out_data, bus.xfer_count);
    end
  endtask
  task automatic test_pass_through();
    drive(1'b1, 16'hAAAA, 1'b0);
    tick();
    drive(1'b1, 16'h5555, 1'b1);
    tests++;
    if (bus.out_data !== 16'hAAAA || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pass_head: data=%h rdy=%b want aaaa 1", bus.out_data, bus.in_ready);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5555 || bus.in_ready !== 1'b1 ||
        bus.xfer_count !== 8'h04) begin
      fails++;
      $display("FAIL pass_swap: vld=%b data=%h rdy=%b cnt=%h want 1 5555 1 04",
               bus.out_valid, bus.out_data, bus.in_ready, bus.xfer_count);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.xfer_count !== 8'h05) begin
      fails++;
      $display("FAIL pass_drain: vld=%b cnt=%h want 0 05", bus.out_valid, bus.xfer_count);
    end
  endtask
  task automatic test_flags();
    drive(1'b1, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 1'b0);
    tests++;
    if (bus.zero_flag !== FL || bus.neg_flag !== 1'b0) begin
      fails++;
      $display("FAIL flags_zero: z=%b n=%b want %b 0", bus.zero_flag, bus.neg_flag, FL);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b1);
    tick();
    tests++;
    if (bus.out_data !== 16'hFFFF || bus.zero_flag !== 1'b0 || bus.neg_flag !== FL) begin
      fails++;
      $display("FAIL flags_neg: data=%h z=%b n=%b want ffff 0 %b",
               bus.out_data, bus.zero_flag, bus.neg_flag, FL);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.zero_flag !== 1'b0 || bus.neg_flag !== 1'b0) begin
      fails++;
      $display("FAIL flags_empty: vld=%b z=%b n=%b want 0 0 0", bus.out_valid, bus.zero_flag, bus.neg_flag);
    end
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 16'h1111, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 16'h3333, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h4444, 1'b1);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
        bus.zero_flag !== 1'b0 || bus.neg_flag !== 1'b0 || bus.xfer_count !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: rdy=%b vld=%b data=%h z=%b n=%b cnt=%h want 1 0 0000 0 0 00",
               bus.in_ready, bus.out_valid, bus.out_data, bus.zero_flag, bus.neg_flag, bus.xfer_count);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4444 || bus.xfer_count !== 8'h00) begin
      fails++;
      $display("FAIL reset_first: vld=%b data=%h cnt=%h want 1 4444 00",
               bus.out_valid, bus.out_data, bus.xfer_count);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.xfer_count !== 8'h01) begin
      fails++;
      $display("FAIL reset_stale: vld=%b data=%h cnt=%h want 0 0000 01",
               bus.out_valid, bus.out_data, bus.xfer_count);
    end
  endtask
  task automatic test_stream();
    logic [15:0] q[$];
    logic [7:0]  mcnt;
    logic        iv, ordy, ix, ox;
    logic [15:0] d, h;
    int          total;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    tick();
    rst_n = 1'b1;
    mcnt  = 8'h00;
    total = 0;
    for (int c = 0; c < 1200; c++) begin
      iv   = c < 1000 && $urandom_range(0, 3) != 0;
      ordy = c >= 1000 || $urandom_range(0, 3) != 0;
      d    = 16'($urandom_range(0, 65535));
      if (c % 97 == 0) d = 16'h0000;
      drive(iv, d, ordy);
      h = q.size() > 0 ? q[0] : 16'h0000;
      tests++;
      if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0) || bus.out_data !== h ||
          bus.xfer_count !== mcnt || bus.zero_flag !== (FL && q.size() > 0 && h == 16'h0000) ||
          bus.neg_flag !== (FL && q.size() > 0 && h[15])) begin
        fails++;
        $display("FAIL stream c=%0d: rdy=%b vld=%b data=%h cnt=%h z=%b n=%b want rdy=%b vld=%b data=%h cnt=%h",
                 c, bus.in_ready, bus.out_valid, bus.out_data, bus.xfer_count, bus.zero_flag, bus.neg_flag,
                 q.size() < 2, q.size() > 0, h, mcnt);
      end
      ix = iv && q.size() < 2;
      ox = ordy && q.size() > 0;
      tick();
      if (ox) begin
        void'(q.pop_front());
        mcnt++;
        total++;
      end
      if (ix) q.push_back(d);
    end
    drive(1'b0, 16'h0000, 1'b0);
    tests++;
    if (total < 256 || q.size() != 0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: transfers=%0d left=%0d vld=%b want >=256 0 0", total, q.size(), bus.out_valid);
    end
  endtask
  initial begin
    drive(1'b0, 16'h0000, 1'b0);
    test_reset();
    test_single();
    test_fill();
    test_pass_through();
    test_flags();
    test_reset_mid();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
